decoder_scan_nto2n: RTL and testbench

//  Registered, parametrised N-to-NUM_OUT one-hot decoder; successor to the fixed 4-to-16 combinational decoder.
//  Two modes: DIRECT (decode a handshaked select, 1-cycle latency) and SCAN (auto-walk outputs, strobe/row driver).

---
 rtl/decoder_scan_nto2n_if.sv | 28 ++
 rtl/decoder_scan_nto2n.sv | 149 ++++++++++++++
 tb/tb_decoder_scan_nto2n.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/decoder_scan_nto2n_if.sv
// Bus bundle for decoder_scan_nto2n: select handshake, scan control and decoded outputs.
interface decoder_scan_nto2n_if #(
  parameter int SEL_W   = 4,
  parameter int NUM_OUT = 16,
  parameter int DWELL_W = 8
);
  logic               enable;
  logic               mode;
  logic               sel_valid;
  logic               sel_ready;
  logic [SEL_W-1:0]   sel;
  logic [DWELL_W-1:0] dwell;
  logic [NUM_OUT-1:0] o;
  logic [SEL_W-1:0]   o_idx;
  logic               o_valid;
  logic               wrap;
  logic               err;

  modport master (
    output enable, mode, sel_valid, sel, dwell,
    input  sel_ready, o, o_idx, o_valid, wrap, err
  );

  modport slave (
    input  enable, mode, sel_valid, sel, dwell,
    output sel_ready, o, o_idx, o_valid, wrap, err
  );
endinterface

// File: rtl/decoder_scan_nto2n.sv
// Registered N-to-NUM_OUT one-hot decoder with DIRECT (handshaked select) and SCAN (auto-walk) modes.
// Optional per-index scan dwell enabled by defining SCAN_DWELL_EN.
//   state     | meaning
//   ST_IDLE   | disabled or switching mode; outputs inactive
//   ST_DIRECT | accept sel each cycle, decode one cycle later
//   ST_SCAN   | walk o_idx 0..NUM_OUT-1, wrap pulses on return to 0
module decoder_scan_nto2n #(
  parameter int SEL_W      = 4,
  parameter int NUM_OUT    = 16,
  parameter int DWELL_W    = 8,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  decoder_scan_nto2n_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  localparam logic [SEL_W:0]   NUM_OUT_X = (SEL_W+1)'(NUM_OUT);
  localparam logic [SEL_W-1:0] LAST_IDX  = SEL_W'(NUM_OUT - 1);
  localparam logic             AL        = (ACTIVE_LOW != 0);

  state_t             state_q, state_d;
  logic [NUM_OUT-1:0] o_q, o_d, hot;
  logic [SEL_W-1:0]   o_idx_q, o_idx_d;
  logic               o_valid_q, o_valid_d;
  logic               wrap_q, wrap_d;
  logic               err_q, err_d;
  logic               sel_ready_q, sel_ready_d;
  logic               accept;
  logic               advance;

`ifdef SCAN_DWELL_EN
  logic [DWELL_W-1:0] cnt_q, cnt_d, dwell_load;

  // dwell==0 is treated as a one-cycle dwell
  assign dwell_load = (bus.dwell == '0) ? '0 : bus.dwell - DWELL_W'(1);
  assign advance    = (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  logic unused_dwell;
  assign unused_dwell = ^bus.dwell;
  assign advance      = 1'b1;
`endif

  assign accept = sel_ready_q & bus.sel_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (bus.enable) state_d = bus.mode ? ST_SCAN : ST_DIRECT;
      ST_DIRECT: if (!bus.enable || bus.mode) state_d = ST_IDLE;
      ST_SCAN:   if (!bus.enable || !bus.mode) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output flops are loaded from the next state so mode entry is visible in the first cycle.
  always_comb begin
    o_idx_d     = o_idx_q;
    o_valid_d   = o_valid_q;
    wrap_d      = 1'b0;
    err_d       = 1'b0;
    sel_ready_d = (state_d == ST_DIRECT);
`ifdef SCAN_DWELL_EN
    cnt_d       = '0;
`endif
    case (state_d)
      ST_DIRECT: begin
        if (accept) begin
          if ({1'b0, bus.sel} < NUM_OUT_X) begin
            o_idx_d   = bus.sel;
            o_valid_d = 1'b1;
          end else begin
            o_valid_d = 1'b0;
            err_d     = 1'b1;
          end
        end
      end
      ST_SCAN: begin
        o_valid_d = 1'b1;
        if (state_q != ST_SCAN) begin
          o_idx_d = '0;
`ifdef SCAN_DWELL_EN
          cnt_d   = dwell_load;
`endif
        end else if (advance) begin
          wrap_d  = (o_idx_q == LAST_IDX);
          o_idx_d = wrap_d ? '0 : o_idx_q + SEL_W'(1);
`ifdef SCAN_DWELL_EN
          cnt_d   = dwell_load;
        end else begin
          cnt_d   = cnt_q - DWELL_W'(1);
`endif
        end
      end
      default: begin
        o_idx_d   = '0;
        o_valid_d = 1'b0;
      end
    endcase

    hot = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      hot[i] = o_valid_d && (o_idx_d == SEL_W'(i));
    end
    o_d = AL ? ~hot : hot;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_q         <= {NUM_OUT{AL}};
      o_idx_q     <= '0;
      o_valid_q   <= 1'b0;
      wrap_q      <= 1'b0;
      err_q       <= 1'b0;
      sel_ready_q <= 1'b0;
    end else begin
      o_q         <= o_d;
      o_idx_q     <= o_idx_d;
      o_valid_q   <= o_valid_d;
      wrap_q      <= wrap_d;
      err_q       <= err_d;
      sel_ready_q <= sel_ready_d;
    end
  end

  assign bus.o         = o_q;
  assign bus.o_idx     = o_idx_q;
  assign bus.o_valid   = o_valid_q;
  assign bus.wrap      = wrap_q;
  assign bus.err       = err_q;
  assign bus.sel_ready = sel_ready_q;

endmodule

// File: tb/tb_decoder_scan_nto2n.sv
// Scoreboard bench for decoder_scan_nto2n: A = 16 outputs active-high, B = 10 outputs active-low.
module tb_decoder_scan_nto2n;

  typedef struct {
    int          stamp;
    logic [15:0] o;
    logic [3:0]  idx;
    bit          idx_dc;
    bit          v;
    bit          w;
    bit          e;
    bit          r;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  exp_t qa[$];
  exp_t qb[$];

  decoder_scan_nto2n_if #(.SEL_W(4), .NUM_OUT(16), .DWELL_W(8)) ifa ();
  decoder_scan_nto2n_if #(.SEL_W(4), .NUM_OUT(10), .DWELL_W(8)) ifb ();

  decoder_scan_nto2n #(.SEL_W(4), .NUM_OUT(16), .DWELL_W(8), .ACTIVE_LOW(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa.slave)
  );
  decoder_scan_nto2n #(.SEL_W(4), .NUM_OUT(10), .DWELL_W(8), .ACTIVE_LOW(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
  endtask

  // Expected response for the edge that follows the current inputs.
  task automatic push(input bit b, input logic [15:0] o, input logic [3:0] idx, input bit dc,
                      input bit v, input bit w, input bit e, input bit r);
    exp_t x;
    x.stamp = cyc + 1; x.o = o; x.idx = idx; x.idx_dc = dc;
    x.v = v; x.w = w; x.e = e; x.r = r;
    if (b) qb.push_back(x);
    else   qa.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] oh_a(input logic [3:0] idx);
    return 16'h0001 << idx;
  endfunction

  function automatic logic [15:0] oc_b(input logic [3:0] idx);
    return (~(16'h0001 << idx)) & 16'h03FF;
  endfunction

  task automatic cmp_a(input exp_t x);
    chk("A.o", 32'(ifa.o), 32'(x.o));
    if (!x.idx_dc) chk("A.o_idx", 32'(ifa.o_idx), 32'(x.idx));
    chk("A.o_valid", 32'(ifa.o_valid), 32'(x.v));
    chk("A.wrap", 32'(ifa.wrap), 32'(x.w));
    chk("A.err", 32'(ifa.err), 32'(x.e));
    chk("A.sel_ready", 32'(ifa.sel_ready), 32'(x.r));
  endtask

  task automatic cmp_b(input exp_t x);
    chk("B.o", 32'(ifb.o), 32'(x.o));
    if (!x.idx_dc) chk("B.o_idx", 32'(ifb.o_idx), 32'(x.idx));
    chk("B.o_valid", 32'(ifb.o_valid), 32'(x.v));
    chk("B.wrap", 32'(ifb.wrap), 32'(x.w));
    chk("B.err", 32'(ifb.err), 32'(x.e));
    chk("B.sel_ready", 32'(ifb.sel_ready), 32'(x.r));
  endtask

  // Monitor: pops each expectation on the cycle it is due.
  always @(negedge clk) begin
    while (qa.size() > 0 && qa[0].stamp < cyc) begin
      chk("A.stale_expectation", 32'(qa[0].stamp), 32'(cyc));
      void'(qa.pop_front());
    end
    if (qa.size() > 0 && qa[0].stamp == cyc) cmp_a(qa.pop_front());
    while (qb.size() > 0 && qb[0].stamp < cyc) begin
      chk("B.stale_expectation", 32'(qb[0].stamp), 32'(cyc));
      void'(qb.pop_front());
    end
    if (qb.size() > 0 && qb[0].stamp == cyc) cmp_b(qb.pop_front());
  end

  initial begin
    logic [3:0] ix;
    ifa.enable = 1'b0; ifa.mode = 1'b0; ifa.sel_valid = 1'b0; ifa.sel = '0; ifa.dwell = '0;
    ifb.enable = 1'b0; ifb.mode = 1'b0; ifb.sel_valid = 1'b0; ifb.sel = '0; ifb.dwell = '0;

    // reset state
    push(0, 16'h0000, 4'd0, 0, 0, 0, 0, 0);
    push(1, 16'h03FF, 4'd0, 0, 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;

    // A: DIRECT sweep 0..15, one-cycle latency, then hold
    ifa.enable = 1'b1; ifa.mode = 1'b0;
    push(0, 16'h0000, 4'd0, 1, 0, 0, 0, 1); tick();
    ifa.sel_valid = 1'b1;
    for (int s = 0; s < 16; s++) begin
      ifa.sel = 4'(s);
      push(0, oh_a(4'(s)), 4'(s), 0, 1, 0, 0, 1); tick();
    end
    ifa.sel_valid = 1'b0;
    push(0, 16'h8000, 4'd15, 0, 1, 0, 0, 1); tick();

    // A: mode change -> one IDLE cycle, then scan 0..15, 0 (wrap), up to idx 7
    ifa.mode = 1'b1;
    push(0, 16'h0000, 4'd0, 1, 0, 0, 0, 0); tick();
    for (int k = 0; k < 24; k++) begin
      ix = 4'(k % 16);
      push(0, oh_a(ix), ix, 0, 1, (k == 16), 0, 0); tick();
    end

    // A: drop enable at idx 7, re-enable restarts at 0 without wrap
    ifa.enable = 1'b0;
    push(0, 16'h0000, 4'd0, 1, 0, 0, 0, 0); tick();
    ifa.enable = 1'b1;
    push(0, 16'h0001, 4'd0, 0, 1, 0, 0, 0); tick();
    push(0, 16'h0002, 4'd1, 0, 1, 0, 0, 0); tick();
    ifa.mode = 1'b0;
    push(0, 16'h0000, 4'd0, 1, 0, 0, 0, 0); tick();
    push(0, 16'h0000, 4'd0, 1, 0, 0, 0, 1); tick();
    ifa.sel_valid = 1'b1; ifa.sel = 4'd3;
    push(0, 16'h0008, 4'd3, 0, 1, 0, 0, 1); tick();
    ifa.sel_valid = 1'b0;

`ifdef SCAN_DWELL_EN
    // A: dwell 3, changed to 5 while index 1 is held; takes effect at index 2
    begin
      int tab [12] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 2, 2, 3};
      ifa.dwell = 8'd3; ifa.mode = 1'b1;
      push(0, 16'h0000, 4'd0, 1, 0, 0, 0, 0); tick();
      for (int k = 0; k < 12; k++) begin
        if (k == 4) ifa.dwell = 8'd5;
        ix = 4'(tab[k]);
        push(0, oh_a(ix), ix, 0, 1, 0, 0, 0); tick();
      end
      ifa.dwell = 8'd0; ifa.mode = 1'b0;
      push(0, 16'h0000, 4'd0, 1, 0, 0, 0, 0); tick();
    end
`endif

    // B: active-low DIRECT, out-of-range selects raise err for one cycle
    ifb.enable = 1'b1; ifb.mode = 1'b0;
    push(1, 16'h03FF, 4'd0, 1, 0, 0, 0, 1); tick();
    ifb.sel_valid = 1'b1;
    ifb.sel = 4'd5;  push(1, 16'h03DF, 4'd5, 0, 1, 0, 0, 1); tick();
    ifb.sel = 4'd9;  push(1, 16'h01FF, 4'd9, 0, 1, 0, 0, 1); tick();
    ifb.sel = 4'd12; push(1, 16'h03FF, 4'd9, 0, 0, 0, 1, 1); tick();
    ifb.sel_valid = 1'b0;
    push(1, 16'h03FF, 4'd9, 0, 0, 0, 0, 1); tick();
    ifb.sel_valid = 1'b1;
    ifb.sel = 4'd10; push(1, 16'h03FF, 4'd9, 0, 0, 0, 1, 1); tick();
    ifb.sel = 4'd0;  push(1, 16'h03FE, 4'd0, 0, 1, 0, 0, 1); tick();
    ifb.sel_valid = 1'b0;

    // B: scan over 10 outputs, wrap on the return to 0, stop at idx 4
    ifb.mode = 1'b1;
    push(1, 16'h03FF, 4'd0, 1, 0, 0, 0, 0); tick();
    for (int k = 0; k < 15; k++) begin
      ix = 4'(k % 10);
      push(1, oc_b(ix), ix, 0, 1, (k == 10), 0, 0); tick();
    end

    // async reset mid-scan, checked before any clock edge
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("B.rst_o", 32'(ifb.o), 32'h3FF);
    chk("B.rst_o_idx", 32'(ifb.o_idx), 32'h0);
    chk("B.rst_o_valid", 32'(ifb.o_valid), 32'h0);
    chk("B.rst_wrap", 32'(ifb.wrap), 32'h0);
    chk("B.rst_err", 32'(ifb.err), 32'h0);
    chk("B.rst_sel_ready", 32'(ifb.sel_ready), 32'h0);
    chk("A.rst_o", 32'(ifa.o), 32'h0);
    chk("A.rst_o_valid", 32'(ifa.o_valid), 32'h0);
    chk("A.queue_drained", 32'(qa.size()), 32'h0);
    chk("B.queue_drained", 32'(qb.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
